core_run_ctrl: RTL and testbench

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

---
 rtl/core_run_ctrl.sv | 136 +++++++++++++
 tb/tb_core_run_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// Run controller for a small core: loads a program image into instruction memory,
// sequences core reset, and provides run / halt / single-step control with a retire counter.
module core_run_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RESET_HOLD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              cmd_start,
    input  logic              cmd_halt,
    input  logic              cmd_step,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              core_en,
    input  logic              core_brk,
    output logic [2:0]        state,
    output logic [31:0]       cyc_cnt
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StBoot = 3'd2,
        StRun  = 3'd3,
        StHalt = 3'd4,
        StStep = 3'd5
    } state_e;

    localparam logic [3:0] HoldLast = 4'(RESET_HOLD - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [3:0]        hold_q, hold_d;
    logic [31:0]       cyc_q, cyc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            hold_q  <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = '0;
        cyc_d      = cyc_q;
        ld_ready   = 1'b0;
        core_rst_n = 1'b0;
        core_en    = 1'b0;

        case (state_q)
            StIdle: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    state_d = ld_last ? StBoot : StLoad;
                end else if (cmd_start) begin
                    state_d = StBoot;
                end
            end
            StLoad: begin
                ld_ready = 1'b1;
                if (ld_valid && ld_last) begin
                    state_d = StBoot;
                end
            end
            StBoot: begin
                // Counter runs only while in BOOT so every entry gets the full hold time.
                hold_d = hold_q + 4'd1;
                cyc_d  = '0;
                if (hold_q == HoldLast) begin
                    hold_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                core_rst_n = 1'b1;
                core_en    = 1'b1;
                cyc_d      = cyc_q + 32'd1;
                if (core_brk || cmd_halt) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                core_rst_n = 1'b1;
                if (cmd_halt) begin
                    state_d = StHalt;
                end else if (cmd_start) begin
                    state_d = StBoot;
                end else if (ld_valid) begin
                    state_d = StLoad;
                end else if (cmd_step) begin
                    state_d = StStep;
                end
            end
            StStep: begin
                core_rst_n = 1'b1;
                core_en    = 1'b1;
                cyc_d      = cyc_q + 32'd1;
                state_d    = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Gate on rst so the handshake drops immediately, not just at the state flop.
        if (rst) begin
            ld_ready = 1'b0;
        end

        if (ld_valid && ld_ready) begin
            ptr_d = ld_last ? '0 : ptr_q + ADDR_W'(1);
        end
    end

    assign imem_we    = ld_valid && ld_ready;
    assign imem_waddr = ptr_q;
    assign imem_wdata = ld_data;
    assign state      = state_q;
    assign cyc_cnt    = cyc_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: stimulus queues expected writes and status,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_core_run_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_BOOT = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;
    localparam logic [2:0] S_STEP = 3'd5;

    typedef struct packed {
        logic [2:0]  st;
        logic        en;
        logic        rstn;
        logic        rdy;
        logic [31:0] cyc;
    } stat_t;

    typedef struct packed {
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        cmd_start;
    logic        cmd_halt;
    logic        cmd_step;
    logic        imem_we;
    logic [1:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        core_en;
    logic        core_brk;
    logic [2:0]  state;
    logic [31:0] cyc_cnt;

    stat_t stat_q[$];
    wr_t   wr_q[$];
    stat_t s_exp;
    stat_t s_act;
    wr_t   w_exp;
    int    vectors;
    int    miscompares;

    core_run_ctrl #(
        .ADDR_W     (2),
        .RESET_HOLD (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .cmd_start  (cmd_start),
        .cmd_halt   (cmd_halt),
        .cmd_step   (cmd_step),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .core_en    (core_en),
        .core_brk   (core_brk),
        .state      (state),
        .cyc_cnt    (cyc_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (imem_we) begin
            vectors++;
            if (wr_q.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write",
                         imem_waddr, imem_wdata);
            end else begin
                w_exp = wr_q.pop_front();
                if (imem_waddr !== w_exp.addr || imem_wdata !== w_exp.data) begin
                    miscompares++;
                    $display("FAIL imem_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             imem_waddr, imem_wdata, w_exp.addr, w_exp.data);
                end
            end
        end
        while (stat_q.size() > 0) begin
            s_exp = stat_q.pop_front();
            s_act = '{st: state, en: core_en, rstn: core_rst_n, rdy: ld_ready, cyc: cyc_cnt};
            vectors++;
            if (s_act !== s_exp) begin
                miscompares++;
                $display("FAIL status @%0t: got st=%0d en=%b rstn=%b rdy=%b cyc=%0d, required st=%0d en=%b rstn=%b rdy=%b cyc=%0d",
                         $time, s_act.st, s_act.en, s_act.rstn, s_act.rdy, s_act.cyc,
                         s_exp.st, s_exp.en, s_exp.rstn, s_exp.rdy, s_exp.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input logic [2:0] st, input logic en, input logic rstn,
                             input logic rdy, input int unsigned cyc);
        stat_q.push_back('{st: st, en: en, rstn: rstn, rdy: rdy, cyc: 32'(cyc)});
    endtask

    task automatic expect_wr(input int unsigned addr, input logic [31:0] data);
        wr_q.push_back('{addr: 2'(addr), data: data});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        ld_valid    = 1'b0;
        ld_data     = '0;
        ld_last     = 1'b0;
        cmd_start   = 1'b0;
        cmd_halt    = 1'b0;
        cmd_step    = 1'b0;
        core_brk    = 1'b0;

        tick();
        expect_st(S_IDLE, 1'b0, 1'b0, 1'b0, 0);
        tick();
        rst = 1'b0;
        expect_st(S_IDLE, 1'b0, 1'b0, 1'b1, 0);
        tick();

        // Four-word image, ld_valid held, last on the fourth word.
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hC0DE_0000 + 32'(i);
            ld_last  = (i == 3);
            expect_wr(i, 32'hC0DE_0000 + 32'(i));
            expect_st((i == 0) ? S_IDLE : S_LOAD, 1'b0, 1'b0, 1'b1, 0);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        expect_st(S_BOOT, 1'b0, 1'b0, 1'b0, 0);
        tick();
        expect_st(S_BOOT, 1'b0, 1'b0, 1'b0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            expect_st(S_RUN, 1'b1, 1'b1, 1'b0, i);
            tick();
        end
        core_brk = 1'b1;
        expect_st(S_RUN, 1'b1, 1'b1, 1'b0, 10);
        tick();
        core_brk = 1'b0;
        expect_st(S_HALT, 1'b0, 1'b1, 1'b0, 11);
        tick();
        expect_st(S_HALT, 1'b0, 1'b1, 1'b0, 11);
        tick();

        // Three spaced single steps.
        for (int k = 0; k < 3; k++) begin
            cmd_step = 1'b1;
            expect_st(S_HALT, 1'b0, 1'b1, 1'b0, 11 + k);
            tick();
            cmd_step = 1'b0;
            expect_st(S_STEP, 1'b1, 1'b1, 1'b0, 11 + k);
            tick();
            expect_st(S_HALT, 1'b0, 1'b1, 1'b0, 12 + k);
            tick();
            expect_st(S_HALT, 1'b0, 1'b1, 1'b0, 12 + k);
            tick();
        end

        // Restart from HALT, then cmd_start alone in RUN is ignored.
        cmd_start = 1'b1;
        expect_st(S_HALT, 1'b0, 1'b1, 1'b0, 14);
        tick();
        cmd_start = 1'b0;
        expect_st(S_BOOT, 1'b0, 1'b0, 1'b0, 14);
        tick();
        expect_st(S_BOOT, 1'b0, 1'b0, 1'b0, 0);
        tick();
        cmd_start = 1'b1;
        expect_st(S_RUN, 1'b1, 1'b1, 1'b0, 0);
        tick();
        cmd_start = 1'b0;
        expect_st(S_RUN, 1'b1, 1'b1, 1'b0, 1);
        tick();
        expect_st(S_RUN, 1'b1, 1'b1, 1'b0, 2);
        tick();

        // cmd_halt and cmd_start together: halt wins, start then honoured from HALT.
        cmd_halt  = 1'b1;
        cmd_start = 1'b1;
        expect_st(S_RUN, 1'b1, 1'b1, 1'b0, 3);
        tick();
        cmd_halt  = 1'b0;
        cmd_start = 1'b0;
        expect_st(S_HALT, 1'b0, 1'b1, 1'b0, 4);
        tick();
        cmd_start = 1'b1;
        expect_st(S_HALT, 1'b0, 1'b1, 1'b0, 4);
        tick();
        cmd_start = 1'b0;
        expect_st(S_BOOT, 1'b0, 1'b0, 1'b0, 4);
        tick();
        expect_st(S_BOOT, 1'b0, 1'b0, 1'b0, 0);
        tick();
        expect_st(S_RUN, 1'b1, 1'b1, 1'b0, 0);
        tick();
        cmd_halt = 1'b1;
        expect_st(S_RUN, 1'b1, 1'b1, 1'b0, 1);
        tick();
        cmd_halt = 1'b0;
        expect_st(S_HALT, 1'b0, 1'b1, 1'b0, 2);
        tick();

        // Reload from HALT: five words on a 4-entry memory wrap to address 0.
        ld_valid = 1'b1;
        ld_data  = 32'hBEEF_0000;
        ld_last  = 1'b0;
        expect_st(S_HALT, 1'b0, 1'b1, 1'b0, 2);
        tick();
        for (int i = 0; i < 5; i++) begin
            ld_data = 32'hBEEF_0000 + 32'(i);
            ld_last = (i == 4);
            expect_wr(i % 4, 32'hBEEF_0000 + 32'(i));
            expect_st(S_LOAD, 1'b0, 1'b0, 1'b1, 2);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        expect_st(S_BOOT, 1'b0, 1'b0, 1'b0, 2);
        tick();
        expect_st(S_BOOT, 1'b0, 1'b0, 1'b0, 0);
        tick();
        expect_st(S_RUN, 1'b1, 1'b1, 1'b0, 0);
        tick();

        // Asynchronous reset between edges while running.
        #2;
        rst = 1'b1;
        expect_st(S_IDLE, 1'b0, 1'b0, 1'b0, 0);
        tick();
        rst = 1'b0;
        expect_st(S_IDLE, 1'b0, 1'b0, 1'b1, 0);
        tick();
        tick();

        vectors++;
        if (wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL writes_outstanding: got %0d expected writes never seen, required 0",
                     wr_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
